inst_decode: RTL and testbench
==============================

Name: inst_decode

Overview:
- RV32I decode stage, directly downstream of the fetch/PC stage.
- Registers each fetched word with its PC and splits it into register indices, funct fields and a sign-extended immediate for the execute stage.
- Resolves JAL itself and redirects fetch.
- Inserts a one-cycle bubble on a load-use hazard, and back-pressures fetch through `busy`.

Parameters:
- RESET_PC, 32'd0: value of `out_pc` after reset.
- NOP_INST, 32'h00000013: instruction word reported while the stage is empty (`addi x0,x0,0`).

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  fetch presents a valid instruction this cycle.
- `in_addr`  in  32  PC of `in_inst`.
- `in_inst`  in  32  instruction word.
- `busy`  out  1  stage cannot accept; fetch must hold its PC.
- `redirect_valid`  out  1  fetch must load `redirect_addr`.
- `redirect_addr`  out  32  JAL target.
- `flush`  in  1  execute-stage redirect (branch/JALR); kills the stage contents.
- `out_busy`  in  1  execute stall.
- `out_valid`  out  1  stage register holds a live instruction.
- `out_pc`  out  32  PC of the held instruction.
- `out_inst`  out  32  raw instruction word.
- `out_opcode`  out  7  `inst[6:0]`.
- `out_rd`  out  5  `inst[11:7]`; forced to 0 for STORE/BRANCH.
- `out_rs1`  out  5  `inst[19:15]`; 0 if not read.
- `out_rs2`  out  5  `inst[24:20]`; 0 if not read.
- `out_funct3`  out  3  `inst[14:12]`.
- `out_funct7`  out  7  `inst[31:25]`.
- `out_imm`  out  32  sign-extended immediate.
- `out_illegal`  out  1  opcode is not an RV32I base opcode.

Behaviour:
- Reset (async), outputs and state:
  - `out_valid`=0, `out_pc`=RESET_PC, `out_inst`=NOP_INST.
  - All decoded fields are those of NOP_INST: `out_opcode`=7'h13, `out_imm`=0.
  - `redirect_valid`=0, `redirect_addr`=0, `out_illegal`=0, `busy`=0.
  - Hazard and redirect-pending state cleared.
- Advance: `adv = !out_busy || !out_valid`.
- `busy = !adv || hazard`.
- Capture, on an edge with `adv` and no hazard:
  - If `in_valid` and no kill: stage loads `in_addr`/`in_inst`; `out_valid`=1.
  - Otherwise: `out_valid`=0 (bubble).
  - Latency is 1 cycle: an instruction accepted at edge N is on `out_*` after edge N.
- Hold: when `!adv`, every `out_*` is held unchanged.
- Decoded fields are combinational from the stage register.
- Immediate by opcode:
  - I-type (03, 13, 67): `inst[31:20]`.
  - S (23): `{inst[31:25], inst[11:7]}`.
  - B (63): `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - U (37, 17): `{inst[31:12], 12'b0}`.
  - J (6F): `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
  - All sign-extended to 32 bits; R-type and others give 0.
- Register-read rules:
  - rs1 is read by every opcode except LUI, AUIPC and JAL.
  - rs2 is read by R-type (33), STORE and BRANCH.
- Load-use hazard:
  - Condition: stage holds a valid LOAD (03) with rd≠0, `adv`=1, `in_valid`=1, and the incoming instruction reads rs1 or rs2 equal to that rd.
  - Response: `hazard`=1, `busy`=1; the next edge captures a bubble.
  - The incoming instruction is captured on the following edge, since the stage is then empty and the hazard clears.
- JAL redirect:
  - Trigger: the edge that captures a JAL sets `redirect_valid`=1 and `redirect_addr = in_addr + J-imm` (mod 2^32, wrap allowed).
  - While `redirect_valid`=1, every `in_valid` instruction is discarded (the wrong-path fall-through).
  - Clears on the first edge with `in_valid`=1 and `busy`=0, i.e. when fetch has taken the new PC.
  - The JAL itself still issues to execute (link value = `out_pc`+4 computed there).
- `flush`:
  - On the edge it is sampled high: `out_valid`=0, `redirect_valid`=0, hazard cleared.
  - The input that cycle is discarded.
  - `flush` has priority over capture, hazard and `out_busy`.
  - Other `out_*` fields may take any value.
- Simultaneous `flush` and a JAL arriving: the JAL is dropped; no redirect is raised.
- Reset asserted mid-operation: immediate return to the reset values, including dropping a pending redirect.

Test Plan:
1. Reset, then `in_inst`=32'h00500093 (`addi x1,x0,5`) at `in_addr`=0 with `in_valid`=1 → next cycle `out_valid`=1, `out_pc`=0, `out_rd`=1, `out_rs1`=0, `out_imm`=5, `busy`=0.
2. Stream of 3 `addi` with `out_busy`=1 on cycles 2–3 → `busy`=1 exactly those cycles, outputs frozen, no instruction lost or duplicated.
3. `lw x2,0(x1)` then `add x3,x2,x2` → `busy`=1 for one cycle, one bubble (`out_valid`=0), then `add` issues with `out_rs1`=`out_rs2`=2.
4. JAL at 0x100 with imm=+0x20 → `redirect_valid`=1, `redirect_addr`=0x120; the 0x104 word is discarded; `redirect_valid` clears once an input is accepted; the next issued PC is 0x120.
5. JAL imm=−8 at 0x4 → `redirect_addr`=0xFFFFFFFC (wrap).
6. `flush` asserted with a valid instruction held, `out_busy`=1, and a pending redirect → next cycle `out_valid`=0, `redirect_valid`=0, `busy`=0.
7. Opcode 7'h7F → `out_illegal`=1, `out_imm`=0.
8. `RST` pulsed mid-stream → outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/inst_decode_if.sv
// Decode-stage bus: fetch-side request/back-pressure/redirect signals plus the
// execute-side stage outputs and stall/flush controls.
//   slave  : the decode stage (inst_decode)
//   master : whoever drives fetch and execute controls (fetch/execute or a bench)
// Fetch side  : in_valid, in_addr, in_inst -> ; <- busy, redirect_valid, redirect_addr
// Execute side: flush, out_busy -> ; <- out_valid, out_pc, out_inst and decoded fields
interface inst_decode_if;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_inst;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        flush;
  logic        out_busy;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_addr, in_inst, flush, out_busy,
    output busy, redirect_valid, redirect_addr,
    output out_valid, out_pc, out_inst, out_opcode, out_rd, out_rs1, out_rs2,
    output out_funct3, out_funct7, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_addr, in_inst, flush, out_busy,
    input  busy, redirect_valid, redirect_addr,
    input  out_valid, out_pc, out_inst, out_opcode, out_rd, out_rs1, out_rs2,
    input  out_funct3, out_funct7, out_imm, out_illegal
  );
endinterface

// File: rtl/inst_decode.sv
// RV32I decode stage.
// Registers each fetched word with its PC, splits it into register indices,
// funct fields and a sign-extended immediate, resolves JAL locally (redirecting
// fetch), and inserts a one-cycle bubble on a load-use hazard.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - inst_decode_if.slave: fetch inputs/back-pressure/redirect and the
//          execute-facing stage register with its decoded fields
module inst_decode #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic         CLK,
  input  logic         RST,
  inst_decode_if.slave bus
);

  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_REG      = 7'h33;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;

  // Sign-extended immediate for any instruction word; formats without an
  // immediate (R-type, unknown opcodes) give zero.
  function automatic logic [31:0] imm_of(input logic [31:0] inst);
    logic [31:0] imm;
    imm = '0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
      OP_STORE:                 imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OP_BRANCH:                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                       inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {inst[31:12], 12'b0};
      OP_JAL:                   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                       inst[30:21], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op == OP_REG || op == OP_STORE || op == OP_BRANCH;
  endfunction

  function automatic logic is_base_op(input logic [6:0] op);
    return op == OP_LOAD  || op == OP_MISC_MEM || op == OP_IMM    || op == OP_AUIPC ||
           op == OP_STORE || op == OP_REG      || op == OP_LUI    || op == OP_BRANCH ||
           op == OP_JALR  || op == OP_JAL      || op == OP_SYSTEM;
  endfunction

  // Stage register and redirect state.
  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        redir_q;
  logic [31:0] redir_addr_q;

  logic       adv;
  logic       hazard;
  logic       busy;
  logic [6:0] stage_op;
  logic [4:0] stage_rd;
  logic [6:0] in_op;

  assign stage_op = inst_q[6:0];
  assign stage_rd = inst_q[11:7];
  assign in_op    = bus.in_inst[6:0];

  // The stage can move whenever execute takes its contents or it is empty.
  assign adv = !bus.out_busy || !valid_q;

  // A load still in this stage has no data yet; an incoming reader of its rd
  // must wait one cycle so the load reaches execute first.
  assign hazard = valid_q && (stage_op == OP_LOAD) && (stage_rd != 5'd0) && adv &&
                  bus.in_valid &&
                  ((reads_rs1(in_op) && (bus.in_inst[19:15] == stage_rd)) ||
                   (reads_rs2(in_op) && (bus.in_inst[24:20] == stage_rd)));

  assign busy = !adv || hazard;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q      <= 1'b0;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      redir_q      <= 1'b0;
      redir_addr_q <= '0;
    end else if (bus.flush) begin
      // Execute is redirecting: everything here is on the wrong path.
      valid_q <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      // Fetch has taken the new PC once it hands us a word we do not stall on;
      // that word is still the wrong-path fall-through and is dropped below.
      if (redir_q && bus.in_valid && !busy) begin
        redir_q <= 1'b0;
      end
      if (adv) begin
        if (!hazard && bus.in_valid && !redir_q) begin
          valid_q <= 1'b1;
          pc_q    <= bus.in_addr;
          inst_q  <= bus.in_inst;
          if (in_op == OP_JAL) begin
            redir_q      <= 1'b1;
            redir_addr_q <= bus.in_addr + imm_of(bus.in_inst);
          end
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy           = busy;
  assign bus.redirect_valid = redir_q;
  assign bus.redirect_addr  = redir_addr_q;

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_inst    = inst_q;
  assign bus.out_opcode  = stage_op;
  assign bus.out_rd      = (stage_op == OP_STORE || stage_op == OP_BRANCH) ? 5'd0 : inst_q[11:7];
  assign bus.out_rs1     = reads_rs1(stage_op) ? inst_q[19:15] : 5'd0;
  assign bus.out_rs2     = reads_rs2(stage_op) ? inst_q[24:20] : 5'd0;
  assign bus.out_funct3  = inst_q[14:12];
  assign bus.out_funct7  = inst_q[31:25];
  assign bus.out_imm     = imm_of(inst_q);
  assign bus.out_illegal = !is_base_op(stage_op);

endmodule

// File: tb/tb_inst_decode.sv
module tb_inst_decode;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  inst_decode_if bus();

  inst_decode #(.RESET_PC(32'd0), .NOP_INST(32'h00000013)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference: instruction semantics ----------------
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int v;
    logic [6:0] op;
    op = w[6:0];
    v = 0;
    if (op inside {7'h03, 7'h13, 7'h67})
      v = int'(w[30:20]) - (w[31] ? 2048 : 0);
    else if (op == 7'h23)
      v = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
    else if (op == 7'h63)
      v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
    else if (op inside {7'h37, 7'h17})
      v = int'(w & 32'hFFFFF000);
    else if (op == 7'h6F)
      v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 -
          (w[31] ? 1048576 : 0);
    return 32'(v);
  endfunction

  function automatic logic ref_rd1(input logic [31:0] w);
    return !(w[6:0] inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic logic ref_rd2(input logic [31:0] w);
    return w[6:0] inside {7'h33, 7'h23, 7'h63};
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;
  } exp_t;

  function automatic exp_t make_exp(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    e.pc      = pc;
    e.inst    = w;
    e.imm     = ref_imm(w);
    e.rd      = (w[6:0] inside {7'h23, 7'h63}) ? 5'd0 : w[11:7];
    e.rs1     = ref_rd1(w) ? w[19:15] : 5'd0;
    e.rs2     = ref_rd2(w) ? w[24:20] : 5'd0;
    e.illegal = !(w[6:0] inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73});
    return e;
  endfunction

  // ---------------- reference: stage behaviour ----------------
  exp_t        sb[$];
  logic        m_valid;
  logic [31:0] m_inst;
  logic        m_redir;
  logic [31:0] m_raddr;

  task automatic model_reset();
    m_valid = 1'b0;
    m_inst  = 32'h00000013;
    m_redir = 1'b0;
    m_raddr = 32'd0;
    sb.delete();
  endtask

  // One clock of stimulus. Entered at posedge+1, returns at the next posedge+1.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] w,
                       input logic ob, input logic fl);
    logic adv, haz, bsy, r_old;
    logic [4:0] ld_rd;
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_inst  = w;
    bus.out_busy = ob;
    bus.flush    = fl;
    @(negedge CLK);
    adv   = !ob || !m_valid;
    ld_rd = m_inst[11:7];
    haz   = m_valid && (m_inst[6:0] == 7'h03) && (ld_rd != 0) && adv && v &&
            ((ref_rd1(w) && w[19:15] == ld_rd) || (ref_rd2(w) && w[24:20] == ld_rd));
    bsy   = !adv || haz;
    check("busy", bus.busy, bsy);
    check("out_valid", bus.out_valid, m_valid);
    check("redirect_valid", bus.redirect_valid, m_redir);
    if (m_redir) check("redirect_addr", bus.redirect_addr, m_raddr);
    @(posedge CLK);
    r_old = m_redir;
    if (fl) begin
      m_valid = 1'b0;
      m_redir = 1'b0;
    end else begin
      if (r_old && v && !bsy) m_redir = 1'b0;
      if (adv) begin
        if (!haz && v && !r_old) begin
          m_valid = 1'b1;
          m_inst  = w;
          sb.push_back(make_exp(a, w));
          if (w[6:0] == 7'h6F) begin
            m_redir = 1'b1;
            m_raddr = a + ref_imm(w);
          end
        end else begin
          m_valid = 1'b0;
        end
      end
    end
    #1;
  endtask

  // ---------------- monitor ----------------
  // An instruction leaves the stage when execute takes it (out_busy low) or a
  // flush kills it; either way it must match the oldest expected entry.
  exp_t mon_e;
  always @(negedge CLK) begin
    if (!RST && bus.out_valid && (!bus.out_busy || bus.flush)) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 32'(bus.out_pc), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("out_pc", bus.out_pc, mon_e.pc);
        check("out_inst", bus.out_inst, mon_e.inst);
        check("out_opcode", 32'(bus.out_opcode), 32'(mon_e.inst[6:0]));
        check("out_funct3", 32'(bus.out_funct3), 32'(mon_e.inst[14:12]));
        check("out_funct7", 32'(bus.out_funct7), 32'(mon_e.inst[31:25]));
        check("out_rd", 32'(bus.out_rd), 32'(mon_e.rd));
        check("out_rs1", 32'(bus.out_rs1), 32'(mon_e.rs1));
        check("out_rs2", 32'(bus.out_rs2), 32'(mon_e.rs2));
        check("out_imm", bus.out_imm, mon_e.imm);
        check("out_illegal", 32'(bus.out_illegal), 32'(mon_e.illegal));
      end
    end
  end

  task automatic check_reset_values();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_inst", bus.out_inst, 32'h00000013);
    check("rst_out_opcode", 32'(bus.out_opcode), 32'h13);
    check("rst_out_imm", bus.out_imm, 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_out_rs1", 32'(bus.out_rs1), 32'd0);
    check("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
    check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("rst_redirect_addr", bus.redirect_addr, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
  endtask

  localparam logic [6:0] OP_POOL [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                                          7'h17, 7'h6F, 7'h33, 7'h0F, 7'h73, 7'h7F};

  // Small register indices keep load-use hazards frequent.
  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    w        = $urandom;
    w[6:0]   = OP_POOL[$urandom_range(0, 11)];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  localparam logic [31:0] NOP = 32'h00000013;

  initial begin
    RST = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_inst  = NOP;
    bus.out_busy = 1'b0;
    bus.flush    = 1'b0;
    model_reset();
    #2;
    check_reset_values();
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // addi x1,x0,5 at PC 0: one-cycle latency.
    cycle(1, 32'h0, 32'h00500093, 0, 0);
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_out_pc", bus.out_pc, 32'h0);
    check("t1_out_rd", 32'(bus.out_rd), 32'd1);
    check("t1_out_rs1", 32'(bus.out_rs1), 32'd0);
    check("t1_out_imm", bus.out_imm, 32'd5);
    check("t1_busy", 32'(bus.busy), 32'd0);
    cycle(0, 32'h0, NOP, 0, 0);

    // Three addi with execute stalled for two cycles; fetch holds while busy.
    cycle(1, 32'h10, 32'h00100213, 0, 0);
    cycle(1, 32'h14, 32'h00200293, 1, 0);
    cycle(1, 32'h14, 32'h00200293, 1, 0);
    cycle(1, 32'h14, 32'h00200293, 0, 0);
    cycle(1, 32'h18, 32'h00300313, 0, 0);
    cycle(0, 32'h0, NOP, 0, 0);

    // lw x2,0(x1) followed by add x3,x2,x2: one bubble.
    cycle(1, 32'h20, 32'h0000A103, 0, 0);
    cycle(1, 32'h24, 32'h002101B3, 0, 0);
    check("t3_bubble", 32'(bus.out_valid), 32'd0);
    cycle(1, 32'h24, 32'h002101B3, 0, 0);
    check("t3_add_valid", 32'(bus.out_valid), 32'd1);
    check("t3_add_rs1", 32'(bus.out_rs1), 32'd2);
    check("t3_add_rs2", 32'(bus.out_rs2), 32'd2);
    cycle(0, 32'h0, NOP, 0, 0);

    // jal x1,+0x20 at 0x100.
    cycle(1, 32'h100, 32'h020000EF, 0, 0);
    check("t4_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    check("t4_redirect_addr", bus.redirect_addr, 32'h120);
    cycle(1, 32'h104, 32'h00700393, 0, 0);
    check("t4_redirect_cleared", 32'(bus.redirect_valid), 32'd0);
    check("t4_fallthrough_dropped", 32'(bus.out_valid), 32'd0);
    cycle(1, 32'h120, 32'h00800413, 0, 0);
    check("t4_target_pc", bus.out_pc, 32'h120);
    cycle(0, 32'h0, NOP, 0, 0);

    // jal x0,-8 at 0x4 wraps; then flush with it held, stalled and redirect pending.
    cycle(1, 32'h4, 32'hFF9FF06F, 0, 0);
    check("t5_redirect_addr", bus.redirect_addr, 32'hFFFFFFFC);
    cycle(1, 32'h8, 32'h00900493, 1, 1);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd0);

    // JAL arriving together with flush is dropped.
    cycle(1, 32'h200, 32'h020000EF, 0, 1);
    check("flush_jal_redirect", 32'(bus.redirect_valid), 32'd0);
    check("flush_jal_valid", 32'(bus.out_valid), 32'd0);

    // Non-base opcode.
    cycle(1, 32'h300, 32'hABCDE07F, 0, 0);
    check("t7_illegal", 32'(bus.out_illegal), 32'd1);
    check("t7_imm", bus.out_imm, 32'd0);
    cycle(0, 32'h0, NOP, 0, 0);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        cycle(1, 32'h400, 32'h00100093, 0, 0);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.out_busy = 1'b0;
        RST = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
      end
      cycle($urandom_range(0, 3) != 0, $urandom & 32'hFFFFFFFC, gen_inst(),
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end

    for (int n = 0; n < 4; n++) cycle(0, 32'h0, NOP, 0, 0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
